// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RV32 subset (R-type, I-ALU, load, store and,
//   optionally, conditional branch). Sequences FETCH -> DECODE -> EXECUTE ->
//   [MEM] -> [WB] and traps on illegal opcodes or on a memory that fails to
//   acknowledge within TIMEOUT cycles. Counts retired instructions.
//
//   Build option: define RISCV_BRANCH_EN to make opcode 1100011 legal. Without
//   it that opcode traps as illegal and pc_sel is held at 0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   instruction           instruction register contents (valid from DECODE)
//   imem_ack, dmem_ack    memory handshake completions
//   branch_taken          branch comparison result from the datapath
//   imem_req, ir_write_en instruction fetch request / IR load strobe
//   alu_op                ALU operation (add outside EXECUTE/MEM)
//   sel_bw_imm_rs2        ALU operand B: 0 = immediate, 1 = rs2
//   dmem_read_en/_write_en data memory requests
//   wr_back_sel           write-back source: 0 = memory data, 1 = ALU result
//   regfile_write_enable  register file write strobe
//   pc_write_en, pc_sel   PC update strobe / 0 = PC+4, 1 = branch target
//   illegal_instr         sticky: unsupported opcode decoded
//   bus_error             sticky: memory acknowledge timeout
//   retired_count         completed instructions, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int instr_width  = 32,
    parameter int alu_op_width = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [instr_width-1:0]  instruction,
    input  logic                    imem_ack,
    input  logic                    dmem_ack,
    input  logic                    branch_taken,
    output logic                    imem_req,
    output logic                    ir_write_en,
    output logic [alu_op_width-1:0] alu_op,
    output logic                    sel_bw_imm_rs2,
    output logic                    dmem_read_en,
    output logic                    dmem_write_en,
    output logic                    wr_back_sel,
    output logic                    regfile_write_enable,
    output logic                    pc_write_en,
    output logic                    pc_sel,
    output logic                    illegal_instr,
    output logic                    bus_error,
    output logic [CNT_WIDTH-1:0]    retired_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [alu_op_width-1:0] ALU_ADD  = alu_op_width'(0);
    localparam logic [alu_op_width-1:0] ALU_SUB  = alu_op_width'(1);
    localparam logic [alu_op_width-1:0] ALU_SLL  = alu_op_width'(2);
    localparam logic [alu_op_width-1:0] ALU_SLT  = alu_op_width'(3);
    localparam logic [alu_op_width-1:0] ALU_SLTU = alu_op_width'(4);
    localparam logic [alu_op_width-1:0] ALU_XOR  = alu_op_width'(5);
    localparam logic [alu_op_width-1:0] ALU_SRL  = alu_op_width'(6);
    localparam logic [alu_op_width-1:0] ALU_SRA  = alu_op_width'(7);
    localparam logic [alu_op_width-1:0] ALU_OR   = alu_op_width'(8);
    localparam logic [alu_op_width-1:0] ALU_AND  = alu_op_width'(9);

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH} cls_t;

    state_t                 r_state;
    cls_t                   r_cls;
    logic [WAIT_W-1:0]      r_wait;
    logic [CNT_WIDTH-1:0]   r_retired;
    logic                   r_illegal;
    logic                   r_bus_error;

    logic [6:0]             w_opcode;
    logic [2:0]             w_func3;
    logic [6:0]             w_func7;
    logic                   w_legal;
    cls_t                   w_cls;
    logic [alu_op_width-1:0] w_alu_op;
    logic [WAIT_W-1:0]      w_wait_inc;
    logic                   w_unused;

    assign w_opcode   = instruction[6:0];
    assign w_func3    = instruction[14:12];
    assign w_func7    = instruction[31:25];
    assign w_wait_inc = r_wait + 1'b1;

    // Register/immediate fields are consumed by the datapath, not here.
`ifdef RISCV_BRANCH_EN
    assign w_unused = ^{instruction[24:15], instruction[11:7]};
`else
    assign w_unused = ^{instruction[24:15], instruction[11:7], branch_taken};
`endif

    // Opcode legality and instruction class
    always_comb begin
        w_legal = 1'b1;
        w_cls   = C_BRANCH;
        case (w_opcode)
            OP_R:     w_cls = C_R;
            OP_I:     w_cls = C_I;
            OP_LOAD:  w_cls = C_LOAD;
            OP_STORE: w_cls = C_STORE;
`ifdef RISCV_BRANCH_EN
            OP_BRANCH: w_cls = C_BRANCH;
`endif
            default:  w_legal = 1'b0;
        endcase
    end

    // ALU operation from func3/func7; I-ALU never uses the sub encoding.
    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_opcode == OP_R || w_opcode == OP_I) begin
            case (w_func3)
                3'b000:  w_alu_op = (w_opcode == OP_R && w_func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'b001:  w_alu_op = ALU_SLL;
                3'b010:  w_alu_op = ALU_SLT;
                3'b011:  w_alu_op = ALU_SLTU;
                3'b100:  w_alu_op = ALU_XOR;
                3'b101:  w_alu_op = (w_func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                3'b110:  w_alu_op = ALU_OR;
                default: w_alu_op = ALU_AND;
            endcase
        end
`ifdef RISCV_BRANCH_EN
        else if (w_opcode == OP_BRANCH) begin
            w_alu_op = ALU_SUB;
        end
`endif
    end

    // State, wait counter, sticky traps and retirement counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_cls       <= C_R;
            r_wait      <= '0;
            r_retired   <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if (pc_write_en) begin
                r_retired <= r_retired + 1'b1;
            end
            // The counter only runs while waiting; holding it at zero elsewhere
            // guarantees it starts from zero on entry to FETCH or MEM.
            r_wait <= '0;
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_state <= DECODE;
                    end else if (w_wait_inc == WAIT_W'(TIMEOUT)) begin
                        r_state     <= TRAP;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                DECODE: begin
                    r_cls <= w_cls;
                    if (w_legal) begin
                        r_state <= EXECUTE;
                    end else begin
                        r_state   <= TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                EXECUTE: begin
                    case (r_cls)
                        C_LOAD, C_STORE: r_state <= MEM;
                        C_BRANCH:        r_state <= FETCH;
                        default:         r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        r_state <= (r_cls == C_LOAD) ? WB : FETCH;
                    end else if (w_wait_inc == WAIT_W'(TIMEOUT)) begin
                        r_state     <= TRAP;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                WB:      r_state <= FETCH;
                TRAP:    r_state <= TRAP;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Strobes decode from the state register; the handshake-completing ones
    // (ir_write_en, store retirement) also need the same-cycle ack.
    always_comb begin
        imem_req             = 1'b0;
        ir_write_en          = 1'b0;
        alu_op               = ALU_ADD;
        dmem_read_en         = 1'b0;
        dmem_write_en        = 1'b0;
        wr_back_sel          = 1'b0;
        regfile_write_enable = 1'b0;
        pc_write_en          = 1'b0;
        pc_sel               = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    imem_req    = 1'b1;
                    ir_write_en = imem_ack;
                end
                EXECUTE: begin
                    alu_op = w_alu_op;
`ifdef RISCV_BRANCH_EN
                    if (r_cls == C_BRANCH) begin
                        pc_write_en = 1'b1;
                        pc_sel      = branch_taken;
                    end
`endif
                end
                MEM: begin
                    alu_op        = w_alu_op;
                    dmem_read_en  = (r_cls == C_LOAD);
                    dmem_write_en = (r_cls == C_STORE);
                    pc_write_en   = (r_cls == C_STORE) && dmem_ack;
                end
                WB: begin
                    regfile_write_enable = 1'b1;
                    pc_write_en          = 1'b1;
                    wr_back_sel          = (r_cls != C_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign sel_bw_imm_rs2 = !(w_opcode == OP_I || w_opcode == OP_LOAD || w_opcode == OP_STORE);
    assign illegal_instr  = r_illegal;
    assign bus_error      = r_bus_error;
    assign retired_count  = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic          imem_ack, dmem_ack, branch_taken;
    logic          imem_req, ir_write_en, sel_bw_imm_rs2;
    logic [3:0]    alu_op;
    logic          dmem_read_en, dmem_write_en, wr_back_sel, regfile_write_enable;
    logic          pc_write_en, pc_sel, illegal_instr, bus_error;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    multicycle_controller #(
        .instr_width(32), .alu_op_width(4), .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_write_en(ir_write_en), .alu_op(alu_op),
        .sel_bw_imm_rs2(sel_bw_imm_rs2), .dmem_read_en(dmem_read_en),
        .dmem_write_en(dmem_write_en), .wr_back_sel(wr_back_sel),
        .regfile_write_enable(regfile_write_enable), .pc_write_en(pc_write_en),
        .pc_sel(pc_sel), .illegal_instr(illegal_instr), .bus_error(bus_error),
        .retired_count(retired_count)
    );

    typedef struct {
        int            cycles;
        bit            rf_we;
        bit            wbsel;
        bit            pcsel;
        logic [3:0]    alu;
        bit            sel;
        int            dcyc;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec  = 0;
    int            n_miss = 0;
    logic [CW-1:0] model_ret;

    // Reset with strobe checks; leaves the bench 2 time units after a rising edge.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        instruction = 32'h0;
        @(posedge clk); #1;
        n_vec++;
        if ({imem_req, ir_write_en, dmem_read_en, dmem_write_en, regfile_write_enable, pc_write_en} !== 6'b0) begin
            n_miss++; $display("FAIL reset_strobes: got %b expected 000000",
                {imem_req, ir_write_en, dmem_read_en, dmem_write_en, regfile_write_enable, pc_write_en});
        end
        n_vec++;
        if ({illegal_instr, bus_error} !== 2'b00) begin
            n_miss++; $display("FAIL reset_traps: got %b expected 00", {illegal_instr, bus_error});
        end
        n_vec++;
        if (retired_count !== '0) begin
            n_miss++; $display("FAIL reset_retired: got %0d expected 0", retired_count);
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_vec++;
        if (imem_req !== 1'b1) begin
            n_miss++; $display("FAIL reset_first_req: got %b expected 1", imem_req);
        end
        model_ret = '0;
        $display("reset done");
    endtask

    // Runs one retiring instruction; the expectation is queued up front and
    // checked when the DUT strobes pc_write_en.
    task automatic exec_instr(input logic [31:0] instr, input int idly, input int ddly,
                              input int exp_cyc, input bit exp_rf, input bit exp_wb,
                              input bit exp_pcs, input logic [3:0] exp_alu,
                              input bit exp_sel, input int exp_dcyc);
        exp_t e;
        int c = 1, mcnt = 0, rfcnt = 0, ircnt = 0;
        bit done = 1'b0, wb_seen = 1'b0, sel_seen = 1'b0, pcs_seen = 1'b0;
        logic [3:0] alu_seen = 4'hx;
        model_ret = model_ret + 1'b1;
        sb_q.push_back('{exp_cyc, exp_rf, exp_wb, exp_pcs, exp_alu, exp_sel, exp_dcyc, model_ret});
        instruction = instr;
        while (!done && c <= 40) begin
            imem_ack = (c == idly + 1);
            dmem_ack = (dmem_read_en || dmem_write_en) && (mcnt == ddly);
            #1;
            if (ir_write_en) ircnt++;
            if (c == idly + 3) begin alu_seen = alu_op; sel_seen = sel_bw_imm_rs2; end
            if (dmem_read_en || dmem_write_en) mcnt++;
            if (regfile_write_enable) begin rfcnt++; wb_seen = wr_back_sel; end
            if (pc_write_en) begin
                pcs_seen = pc_sel;
                e = sb_q.pop_front();
                n_vec++;
                if (c !== e.cycles) begin n_miss++; $display("FAIL latency %h: got %0d expected %0d", instr, c, e.cycles); end
                n_vec++;
                if (rfcnt !== int'(e.rf_we)) begin n_miss++; $display("FAIL rf_we_cycles %h: got %0d expected %0d", instr, rfcnt, e.rf_we); end
                if (e.rf_we) begin
                    n_vec++;
                    if (wb_seen !== e.wbsel) begin n_miss++; $display("FAIL wr_back_sel %h: got %b expected %b", instr, wb_seen, e.wbsel); end
                end
                n_vec++;
                if (pcs_seen !== e.pcsel) begin n_miss++; $display("FAIL pc_sel %h: got %b expected %b", instr, pcs_seen, e.pcsel); end
                n_vec++;
                if (alu_seen !== e.alu) begin n_miss++; $display("FAIL alu_op %h: got %b expected %b", instr, alu_seen, e.alu); end
                n_vec++;
                if (sel_seen !== e.sel) begin n_miss++; $display("FAIL sel_bw %h: got %b expected %b", instr, sel_seen, e.sel); end
                n_vec++;
                if (mcnt !== e.dcyc) begin n_miss++; $display("FAIL dmem_cycles %h: got %0d expected %0d", instr, mcnt, e.dcyc); end
                n_vec++;
                if (ircnt !== 1) begin n_miss++; $display("FAIL ir_write_en %h: got %0d expected 1", instr, ircnt); end
                @(posedge clk); #1;
                n_vec++;
                if (retired_count !== e.ret) begin n_miss++; $display("FAIL retired %h: got %0d expected %0d", instr, retired_count, e.ret); end
                done = 1'b1;
                $display("instr %h: %0d cycles, alu %b, retired %0d", instr, c, alu_seen, retired_count);
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        if (!done) begin
            void'(sb_q.pop_front());
            n_vec++; n_miss++;
            $display("FAIL retire_timeout %h: got no pc_write_en expected within 40 cycles", instr);
            do_reset();
        end
    endtask

    // Illegal opcode: TRAP is entered after DECODE and is absorbing.
    task automatic check_trap(input logic [31:0] instr);
        int c = 1;
        instruction = instr;
        while (c <= 10) begin
            imem_ack = (c == 1); #1;
            if (illegal_instr) break;
            @(posedge clk); #1; c++;
        end
        n_vec++;
        if (c !== 3) begin n_miss++; $display("FAIL illegal_cycle %h: got %0d expected 3", instr, c); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            imem_ack = 1'b1; dmem_ack = 1'b1; #1;
            n_vec++;
            if ({imem_req, ir_write_en, dmem_read_en, dmem_write_en, regfile_write_enable,
                 pc_write_en, illegal_instr, bus_error} !== 8'b0000_0010) begin
                n_miss++; $display("FAIL trap_hold %h: got %b expected 00000010", instr,
                    {imem_req, ir_write_en, dmem_read_en, dmem_write_en, regfile_write_enable,
                     pc_write_en, illegal_instr, bus_error});
            end
        end
        $display("instr %h: trapped illegal at cycle %0d", instr, c);
        do_reset();
    endtask

    // Missing acknowledge: bus_error rises when the wait counter expires.
    task automatic check_bus(input logic [31:0] instr, input bit ack_fetch, input int exp_c);
        int c = 1;
        instruction = instr;
        while (c <= 30) begin
            imem_ack = ack_fetch && (c == 1); dmem_ack = 1'b0; #1;
            if (bus_error) break;
            @(posedge clk); #1; c++;
        end
        n_vec++;
        if (c !== exp_c) begin n_miss++; $display("FAIL bus_error_cycle %h: got %0d expected %0d", instr, c, exp_c); end
        n_vec++;
        if ({imem_req, dmem_read_en, pc_write_en, illegal_instr} !== 4'b0) begin
            n_miss++; $display("FAIL bus_trap_state %h: got %b expected 0000", instr,
                {imem_req, dmem_read_en, pc_write_en, illegal_instr});
        end
        $display("instr %h: bus_error at cycle %0d", instr, c);
        imem_ack = 1'b0;
        do_reset();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_rtype();
        exec_instr(32'h002081B3, 0, 0, 4, 1, 1, 0, 4'b0000, 1, 0);
        exec_instr(32'h402081B3, 0, 0, 4, 1, 1, 0, 4'b0001, 1, 0);
        exec_instr(32'h4020D1B3, 1, 0, 5, 1, 1, 0, 4'b0111, 1, 0);
        exec_instr(32'h0020F1B3, 0, 0, 4, 1, 1, 0, 4'b1001, 1, 0);
    endtask

    task automatic test_ialu();
        exec_instr(32'h40008093, 0, 0, 4, 1, 1, 0, 4'b0000, 0, 0);
        exec_instr(32'h4030D093, 0, 0, 4, 1, 1, 0, 4'b0111, 0, 0);
        exec_instr(32'h0020A093, 0, 0, 4, 1, 1, 0, 4'b0011, 0, 0);
        exec_instr(32'h0020E093, 2, 0, 6, 1, 1, 0, 4'b1000, 0, 0);
    endtask

    task automatic test_load_store();
        exec_instr(32'h0080A283, 0, 2, 7, 1, 0, 0, 4'b0000, 0, 3);
        exec_instr(32'h0080A283, 0, 0, 5, 1, 0, 0, 4'b0000, 0, 1);
        exec_instr(32'h0050A623, 0, 1, 5, 0, 0, 0, 4'b0000, 0, 2);
        exec_instr(32'h0050A623, 0, 0, 4, 0, 0, 0, 4'b0000, 0, 1);
    endtask

    // Randomised R-type stream; long enough to wrap the 4-bit retire counter.
    task automatic test_back_to_back();
        logic [2:0] f3_tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        logic [6:0] f7_tab [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [3:0] op_tab [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        for (int i = 0; i < 12; i++) begin
            int k = $urandom_range(0, 9);
            int d = $urandom_range(0, 2);
            exec_instr({f7_tab[k], 5'd2, 5'd1, f3_tab[k], 5'd3, 7'b0110011}, d, 0, 4 + d,
                       1, 1, 0, op_tab[k], 1, 0);
        end
    endtask

    task automatic test_timeout();
        check_bus(32'h002081B3, 1'b0, TO + 1);
        check_bus(32'h0080A283, 1'b1, TO + 4);
        // Ack arriving in the expiry cycle still completes the fetch.
        exec_instr(32'h002081B3, TO - 1, 0, TO + 3, 1, 1, 0, 4'b0000, 1, 0);
    endtask

    task automatic test_illegal();
        check_trap(32'hFFFFFFFF);
    endtask

    task automatic test_branch();
`ifdef RISCV_BRANCH_EN
        branch_taken = 1'b1;
        exec_instr(32'h00208863, 0, 0, 3, 0, 0, 1, 4'b0001, 1, 0);
        branch_taken = 1'b0;
        exec_instr(32'h00208863, 0, 0, 3, 0, 0, 0, 4'b0001, 1, 0);
`else
        branch_taken = 1'b1;
        check_trap(32'h00208863);
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ialu();
        test_load_store();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_branch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
